// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEB_PRESS,
        HELD,
        DEB_RELEASE
    } kp_state_t;

    // Linear key number from matrix position.
    function automatic int unsigned key_index(input int unsigned row, input int unsigned col,
                                              input int unsigned cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous, active-low column inputs.
// Resets to all ones so no key appears pressed while reset is applied.
module keypad_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             int_osc,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage metastability filter.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner: row drive, column sampling, press/release debounce,
// two-deep key history and optional auto-repeat.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS          = 4,
    parameter int unsigned COLS          = 3,
    parameter int unsigned SCAN_DIV      = 4096,
    parameter int unsigned DEBOUNCE_CYC  = 65536,
    parameter int unsigned REPEAT_EN     = 0,
    parameter int unsigned REPEAT_DELAY  = 2**22,
    parameter int unsigned REPEAT_PERIOD = 2**20,
    localparam int unsigned KEY_W        = $clog2(ROWS * COLS)
) (
    input  logic             int_osc,
    input  logic             reset,
    input  logic [COLS-1:0]  col_n,
    output logic [ROWS-1:0]  row_n,
    output logic             key_valid,
    output logic             key_repeat,
    output logic [KEY_W-1:0] key_code,
    output logic [KEY_W-1:0] key_prev,
    output logic             key_held
);

    localparam int unsigned ROW_W   = $clog2(ROWS);
    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned DW      = $clog2(SCAN_DIV);
    localparam int unsigned DBW     = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPW     = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    localparam logic [DW-1:0]  DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYC - 1);

    logic [COLS-1:0]  cs_n;
    kp_state_t        state_q, state_d;
    logic [DW-1:0]    dwell_q, dwell_d;
    logic [DBW-1:0]   db_q, db_d;
    logic [RPW-1:0]   rpt_q, rpt_d;
    logic             rpt_first_q, rpt_first_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [ROWS-1:0]  row_n_q, row_n_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [KEY_W-1:0] key_code_q, key_code_d;
    logic [KEY_W-1:0] key_prev_q, key_prev_d;
    logic             key_held_q, key_held_d;
    logic             key_valid_q, key_valid_d;
    logic             key_repeat_q, key_repeat_d;

    logic             any_press;
    logic             all_high;
    logic [COL_W-1:0] press_col;
    logic [ROW_W-1:0] row_next;
    logic [RPW-1:0]   rpt_limit;

    keypad_sync #(
        .WIDTH(COLS)
    ) u_sync (
        .int_osc(int_osc),
        .reset  (reset),
        .d      (col_n),
        .q      (cs_n)
    );

    assign any_press = ~&cs_n;
    assign all_high  = &cs_n;
    assign row_next  = (row_idx_q == ROW_W'(ROWS - 1)) ? '0 : row_idx_q + ROW_W'(1);
    // First repeat waits the long delay, later ones use the shorter period.
    assign rpt_limit = rpt_first_q ? RPW'(REPEAT_PERIOD - 1) : RPW'(REPEAT_DELAY - 1);

    // Lowest-numbered low column wins when several are pressed on one row.
    always_comb begin
        press_col = '0;
        for (int i = int'(COLS) - 1; i >= 0; i--) begin
            if (!cs_n[i]) begin
                press_col = COL_W'(i);
            end
        end
    end

    // Scan/debounce/hold FSM next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        db_d         = db_q;
        rpt_d        = rpt_q;
        rpt_first_d  = rpt_first_q;
        row_idx_d    = row_idx_q;
        col_d        = col_q;
        key_code_d   = key_code_q;
        key_prev_d   = key_prev_q;
        key_held_d   = key_held_q;
        key_valid_d  = 1'b0;
        key_repeat_d = 1'b0;

        unique case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_MAX) begin
                    dwell_d = '0;
                    if (any_press) begin
                        col_d   = press_col;
                        db_d    = '0;
                        state_d = DEB_PRESS;
                    end else begin
                        row_idx_d = row_next;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            DEB_PRESS: begin
                if (!cs_n[col_q]) begin
                    if (db_q == DB_MAX) begin
                        key_valid_d = 1'b1;
                        key_prev_d  = key_code_q;
                        key_code_d  = KEY_W'(key_index(32'(row_idx_q), 32'(col_q), COLS));
                        key_held_d  = 1'b1;
                        db_d        = '0;
                        rpt_d       = '0;
                        rpt_first_d = 1'b0;
                        state_d     = HELD;
                    end else begin
                        db_d = db_q + DBW'(1);
                    end
                end else begin
                    db_d      = '0;
                    dwell_d   = '0;
                    row_idx_d = row_next;
                    state_d   = SCAN;
                end
            end
            HELD: begin
                if (all_high) begin
                    // This cycle is already the first stable-high one.
                    db_d    = DBW'(1);
                    state_d = DEB_RELEASE;
                end else if (REPEAT_EN != 0) begin
                    if (rpt_q == rpt_limit) begin
                        // Hold off one cycle if a pulse just went out.
                        if (!key_valid_q) begin
                            key_valid_d  = 1'b1;
                            key_repeat_d = 1'b1;
                            rpt_d        = '0;
                            rpt_first_d  = 1'b1;
                        end
                    end else begin
                        rpt_d = rpt_q + RPW'(1);
                    end
                end
            end
            DEB_RELEASE: begin
                if (all_high) begin
                    if (db_q == DB_MAX) begin
                        key_held_d = 1'b0;
                        db_d       = '0;
                        dwell_d    = '0;
                        row_idx_d  = row_next;
                        state_d    = SCAN;
                    end else begin
                        db_d = db_q + DBW'(1);
                    end
                end else begin
                    // Bounce: back to HELD, repeat timer keeps its position.
                    db_d    = '0;
                    state_d = HELD;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase

        row_n_d = ~(ROWS'(1) << row_idx_d);
    end

    // State, counters, row drive and key history registers.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state_q      <= SCAN;
            dwell_q      <= '0;
            db_q         <= '0;
            rpt_q        <= '0;
            rpt_first_q  <= 1'b0;
            row_idx_q    <= '0;
            row_n_q      <= ~ROWS'(1);
            col_q        <= '0;
            key_code_q   <= '0;
            key_prev_q   <= '0;
            key_held_q   <= 1'b0;
            key_valid_q  <= 1'b0;
            key_repeat_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            db_q         <= db_d;
            rpt_q        <= rpt_d;
            rpt_first_q  <= rpt_first_d;
            row_idx_q    <= row_idx_d;
            row_n_q      <= row_n_d;
            col_q        <= col_d;
            key_code_q   <= key_code_d;
            key_prev_q   <= key_prev_d;
            key_held_q   <= key_held_d;
            key_valid_q  <= key_valid_d;
            key_repeat_q <= key_repeat_d;
        end
    end

    assign row_n      = row_n_q;
    assign key_valid  = key_valid_q;
    assign key_repeat = key_repeat_q;
    assign key_code   = key_code_q;
    assign key_prev   = key_prev_q;
    assign key_held   = key_held_q;

endmodule
